// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants for the fetch path: PC_Src encodings (also used by the PC control unit),
// the bubble encoding and the fetch FSM state type.
package pc_fetch_stage_pkg;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JR  = 2'b10;
   localparam logic [1:0] PC_SRC_JMP = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

   // A redirect only exists when Kill is paired with a non-sequential source.
   function automatic logic is_redirect(input logic kill, input logic [1:0] pc_src);
      return kill && (pc_src != PC_SRC_SEQ);
   endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Bundle between the PC control unit / imem / decode side (master) and the fetch stage (slave).
interface pc_fetch_stage_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 16
);
   import pc_fetch_stage_pkg::*;

   // Kill and Stall are level signals sampled every rising edge; there is no ready back-pressure:
   // a Kill presented while Stall=1 is dropped and must be presented again by decode.
   logic [1:0]         PC_Src;
   logic               Kill;
   logic               Stall;
   logic [ADDR_W-1:0]  Branch_Target;
   logic [ADDR_W-1:0]  JR_Target;
   logic [ADDR_W-1:0]  Jump_Target;
   logic [INSTR_W-1:0] Imem_Instr;
   logic [ADDR_W-1:0]  Imem_Addr;
   logic [INSTR_W-1:0] IF_ID_Instr;
   logic [ADDR_W-1:0]  IF_ID_PC;
   logic [ADDR_W-1:0]  IF_ID_PCnext;
   logic               IF_ID_Valid;
   logic [CNT_W-1:0]   Kill_Cnt;
   logic [CNT_W-1:0]   Stall_Cnt;
   logic               Proto_Err;
   fetch_state_t       Fetch_State;

   modport master (
      output PC_Src, Kill, Stall, Branch_Target, JR_Target, Jump_Target, Imem_Instr,
      input  Imem_Addr, IF_ID_Instr, IF_ID_PC, IF_ID_PCnext, IF_ID_Valid,
             Kill_Cnt, Stall_Cnt, Proto_Err, Fetch_State
   );

   modport slave (
      input  PC_Src, Kill, Stall, Branch_Target, JR_Target, Jump_Target, Imem_Instr,
      output Imem_Addr, IF_ID_Instr, IF_ID_PC, IF_ID_PCnext, IF_ID_Valid,
             Kill_Cnt, Stall_Cnt, Proto_Err, Fetch_State
   );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC source: sequential PC+PC_INC and the 4:1 target select on PC_Src.
module pc_next_mux
   import pc_fetch_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned PC_INC = 1
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [1:0]        pc_src,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic [ADDR_W-1:0] jump_target,
   output logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc_seq
);

   // Wraps silently modulo 2^ADDR_W.
   assign pc_seq = pc + ADDR_W'(PC_INC);

   always_comb begin
      target = pc_seq;
      case (pc_src)
         PC_SRC_BR:  target = branch_target;
         PC_SRC_JR:  target = jr_target;
         PC_SRC_JMP: target = jump_target;
         default:    target = pc_seq;
      endcase
   end

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: owns the PC, drives imem, fills the IF/ID register and squashes the
// wrong-path slot on a redirect. Stall freezes everything and wins over Kill.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter int unsigned        ADDR_W    = 32,
   parameter int unsigned        INSTR_W   = 32,
   parameter int unsigned        CNT_W     = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter int unsigned        PC_INC    = 1,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pc_fetch_stage_pkg::NOP_INSTR)
) (
   input logic             clk,
   input logic             rst_n,
   pc_fetch_stage_if.slave bus
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
   logic [ADDR_W-1:0]  if_next_q, if_next_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   kill_cnt_q, kill_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic               err_q, err_d;

   logic [ADDR_W-1:0]  target;
   logic [ADDR_W-1:0]  pc_seq;
   logic               redirect;

   pc_next_mux #(
      .ADDR_W (ADDR_W),
      .PC_INC (PC_INC)
   ) u_next_mux (
      .pc            (pc_q),
      .pc_src        (bus.PC_Src),
      .branch_target (bus.Branch_Target),
      .jr_target     (bus.JR_Target),
      .jump_target   (bus.Jump_Target),
      .target        (target),
      .pc_seq        (pc_seq)
   );

   assign redirect = is_redirect(bus.Kill, bus.PC_Src);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         instr_q     <= NOP_INSTR;
         if_pc_q     <= '0;
         if_next_q   <= '0;
         valid_q     <= 1'b0;
         kill_cnt_q  <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         if_pc_q     <= if_pc_d;
         if_next_q   <= if_next_d;
         valid_q     <= valid_d;
         kill_cnt_q  <= kill_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      if_pc_d     = if_pc_q;
      if_next_d   = if_next_q;
      valid_d     = valid_q;
      kill_cnt_d  = kill_cnt_q;
      stall_cnt_d = stall_cnt_q;
      err_d       = err_q;

      case (state_q)
         ST_BOOT: begin
            // First edge out of reset only drops a bubble into IF/ID; inputs are not looked at.
            state_d = ST_FETCH;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end

         ST_FETCH, ST_HOLD: begin
            if (bus.Stall) begin
               state_d     = ST_HOLD;
               stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
            end else begin
               state_d = ST_FETCH;
               if (redirect) begin
                  pc_d       = target;
                  instr_d    = NOP_INSTR;
                  valid_d    = 1'b0;
                  kill_cnt_d = (kill_cnt_q == '1) ? kill_cnt_q : kill_cnt_q + CNT_W'(1);
               end else begin
                  pc_d      = pc_seq;
                  instr_d   = bus.Imem_Instr;
                  if_pc_d   = pc_q;
                  if_next_d = pc_seq;
                  valid_d   = 1'b1;
                  // Kill with a sequential source is a control-unit bug; fetch proceeds anyway.
                  if (bus.Kill) begin
                     err_d = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign bus.Imem_Addr    = pc_q;
   assign bus.IF_ID_Instr  = instr_q;
   assign bus.IF_ID_PC     = if_pc_q;
   assign bus.IF_ID_PCnext = if_next_q;
   assign bus.IF_ID_Valid  = valid_q;
   assign bus.Kill_Cnt     = kill_cnt_q;
   assign bus.Stall_Cnt    = stall_cnt_q;
   assign bus.Proto_Err    = err_q;
   assign bus.Fetch_State  = state_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: per-cycle comparison against a behavioural model plus
// literal checkpoints. Counters are instantiated 4 bits wide so saturation is reachable.
module tb_pc_fetch_stage;

   localparam int AW = 32;
   localparam int IW = 32;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   pc_fetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) bus ();

   pc_fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- instruction memory ----------------
   function automatic logic [IW-1:0] imem_fn(input logic [AW-1:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
   endfunction

   assign bus.Imem_Instr = imem_fn(bus.Imem_Addr);

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [AW-1:0] m_pc, m_ifpc, m_ifnext;
   logic [IW-1:0] m_instr;
   logic          m_valid, m_err, m_boot;
   int            m_kc, m_sc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= '0; m_instr <= '0; m_ifpc <= '0; m_ifnext <= '0;
         m_valid <= 1'b0; m_err <= 1'b0; m_kc <= 0; m_sc <= 0; m_boot <= 1'b1;
      end else if (m_boot) begin
         m_boot <= 1'b0; m_valid <= 1'b0; m_instr <= '0;
      end else if (bus.Stall) begin
         m_sc <= (m_sc < CMAX) ? m_sc + 1 : CMAX;
      end else if (bus.Kill && bus.PC_Src != 2'b00) begin
         case (bus.PC_Src)
            2'b01:   m_pc <= bus.Branch_Target;
            2'b10:   m_pc <= bus.JR_Target;
            default: m_pc <= bus.Jump_Target;
         endcase
         m_valid <= 1'b0;
         m_instr <= '0;
         m_kc    <= (m_kc < CMAX) ? m_kc + 1 : CMAX;
      end else begin
         m_instr  <= imem_fn(m_pc);
         m_ifpc   <= m_pc;
         m_ifnext <= m_pc + 1;
         m_valid  <= 1'b1;
         m_pc     <= m_pc + 1;
         if (bus.Kill) m_err <= 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("addr",   64'(bus.Imem_Addr),    64'(m_pc));
      chk("valid",  64'(bus.IF_ID_Valid),  64'(m_valid));
      chk("instr",  64'(bus.IF_ID_Instr),  64'(m_instr));
      chk("if_pc",  64'(bus.IF_ID_PC),     64'(m_ifpc));
      chk("if_nxt", 64'(bus.IF_ID_PCnext), 64'(m_ifnext));
      chk("kcnt",   64'(bus.Kill_Cnt),     64'(m_kc));
      chk("scnt",   64'(bus.Stall_Cnt),    64'(m_sc));
      chk("perr",   64'(bus.Proto_Err),    64'(m_err));
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic stall, input logic kill, input logic [1:0] src,
                        input logic [AW-1:0] tgt);
      bus.Stall         = stall;
      bus.Kill          = kill;
      bus.PC_Src        = src;
      bus.Branch_Target = (src == 2'b01) ? tgt : 32'h0BAD_0001;
      bus.JR_Target     = (src == 2'b10) ? tgt : 32'h0BAD_0002;
      bus.Jump_Target   = (src == 2'b11) ? tgt : 32'h0BAD_0003;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, '0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle();
      repeat (3) tick();
      rst_n = 1'b1;

      // reset release and sequential fetch
      chk("rst_addr", 64'(bus.Imem_Addr), 64'h0);
      chk("rst_valid", 64'(bus.IF_ID_Valid), 64'h0);
      tick(); chk("boot_addr", 64'(bus.Imem_Addr), 64'h0);
      tick(); chk("seq1_addr", 64'(bus.Imem_Addr), 64'h1);
      chk("seq1_ifpc", 64'(bus.IF_ID_PC), 64'h0);
      chk("seq1_valid", 64'(bus.IF_ID_Valid), 64'h1);
      tick(); chk("seq2_addr", 64'(bus.Imem_Addr), 64'h2);
      tick(); chk("seq3_addr", 64'(bus.Imem_Addr), 64'h3);
      repeat (5) tick();
      chk("pc8", 64'(bus.Imem_Addr), 64'h8);

      // branch redirect: one bubble, then target
      drive(1'b0, 1'b1, 2'b01, 32'h40); tick();
      chk("br_addr", 64'(bus.Imem_Addr), 64'h40);
      chk("br_bubble", 64'(bus.IF_ID_Valid), 64'h0);
      chk("br_kcnt", 64'(bus.Kill_Cnt), 64'h1);
      idle(); tick();
      chk("br_ifpc", 64'(bus.IF_ID_PC), 64'h40);
      chk("br_valid", 64'(bus.IF_ID_Valid), 64'h1);

      // jump-register to 4, one fetch, then stall 3 cycles at PC=5
      drive(1'b0, 1'b1, 2'b10, 32'h4); tick();
      idle(); tick();
      chk("pc5", 64'(bus.Imem_Addr), 64'h5);
      drive(1'b1, 1'b0, 2'b00, '0);
      repeat (3) tick();
      chk("stall_addr", 64'(bus.Imem_Addr), 64'h5);
      chk("stall_ifpc", 64'(bus.IF_ID_PC), 64'h4);
      chk("stall_cnt3", 64'(bus.Stall_Cnt), 64'h3);
      idle(); tick();
      chk("resume_addr", 64'(bus.Imem_Addr), 64'h6);
      chk("resume_ifpc", 64'(bus.IF_ID_PC), 64'h5);

      // stall beats kill; kill re-presented afterwards
      drive(1'b1, 1'b1, 2'b11, 32'h80); tick();
      chk("sk_addr", 64'(bus.Imem_Addr), 64'h6);
      chk("sk_kcnt", 64'(bus.Kill_Cnt), 64'h2);
      drive(1'b0, 1'b1, 2'b11, 32'h80); tick();
      chk("sk_jmp", 64'(bus.Imem_Addr), 64'h80);
      chk("sk_kcnt2", 64'(bus.Kill_Cnt), 64'h3);

      // protocol error: Kill with sequential source at PC=3
      drive(1'b0, 1'b1, 2'b01, 32'h3); tick();
      drive(1'b0, 1'b1, 2'b00, '0); tick();
      chk("pe_addr", 64'(bus.Imem_Addr), 64'h4);
      chk("pe_valid", 64'(bus.IF_ID_Valid), 64'h1);
      chk("pe_flag", 64'(bus.Proto_Err), 64'h1);
      idle(); tick();
      chk("pe_sticky", 64'(bus.Proto_Err), 64'h1);

      // back-to-back kills
      drive(1'b0, 1'b1, 2'b01, 32'h100); tick();
      drive(1'b0, 1'b1, 2'b11, 32'h200); tick();
      chk("b2b_addr", 64'(bus.Imem_Addr), 64'h200);
      chk("b2b_valid", 64'(bus.IF_ID_Valid), 64'h0);
      chk("b2b_kcnt", 64'(bus.Kill_Cnt), 64'h6);

      // PC wrap
      drive(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF); tick();
      idle(); tick();
      chk("wrap_addr", 64'(bus.Imem_Addr), 64'h0);
      chk("wrap_ifpc", 64'(bus.IF_ID_PC), 64'hFFFF_FFFF);
      chk("wrap_next", 64'(bus.IF_ID_PCnext), 64'h0);

      // PC_Src without Kill is ignored
      drive(1'b0, 1'b0, 2'b01, 32'h999); tick();
      chk("nokill_addr", 64'(bus.Imem_Addr), 64'h1);

      // async reset in the middle of a hold at PC=0x20
      drive(1'b0, 1'b1, 2'b01, 32'h20); tick();
      drive(1'b1, 1'b0, 2'b00, '0);
      repeat (2) tick();
      chk("hold_cnt", 64'(bus.Stall_Cnt), 64'h6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_addr", 64'(bus.Imem_Addr), 64'h0);
      chk("arst_valid", 64'(bus.IF_ID_Valid), 64'h0);
      chk("arst_ifpc", 64'(bus.IF_ID_PC), 64'h0);
      chk("arst_scnt", 64'(bus.Stall_Cnt), 64'h0);
      chk("arst_kcnt", 64'(bus.Kill_Cnt), 64'h0);
      chk("arst_perr", 64'(bus.Proto_Err), 64'h0);
      tick();
      rst_n = 1'b1;

      // boot edge ignores stall; then stall counter saturates
      tick();
      chk("boot_scnt", 64'(bus.Stall_Cnt), 64'h0);
      repeat (20) tick();
      chk("scnt_sat", 64'(bus.Stall_Cnt), 64'(CMAX));
      chk("scnt_addr", 64'(bus.Imem_Addr), 64'h0);

      // kill counter saturates while PC keeps following the latest target
      for (int i = 0; i < 18; i++) begin
         drive(1'b0, 1'b1, 2'b01, 32'h1000 + 32'(i));
         tick();
      end
      chk("kcnt_sat", 64'(bus.Kill_Cnt), 64'(CMAX));
      chk("kcnt_addr", 64'(bus.Imem_Addr), 64'h1011);
      idle();
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
